// File: rtl/mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arbiter: shares one word-addressed memory port between instruction    |
// | fetch and data load/store, one access at a time with fixed latency.       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int              c_STARVE_W   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_MAX);
  localparam logic [2:0]      c_LAT        = 3'(MEM_LAT);

  generate
    if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_mem_lat
      $fatal(1, "mem_arbiter: MEM_LAT must be within 1..7");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                r_state, w_state;
  logic                  r_owner_if, w_owner_if;
  logic                  r_we, w_we;
  logic [2:0]            r_lat, w_lat;
  logic [c_STARVE_W-1:0] r_starve, w_starve;

  logic              r_if_gnt, w_if_gnt, r_dm_gnt, w_dm_gnt;
  logic              r_if_rvalid, w_if_rvalid, r_dm_rvalid, w_dm_rvalid;
  logic [DATA_W-1:0] r_if_rdata, w_if_rdata, r_dm_rdata, w_dm_rdata;
  logic              r_mem_en, w_mem_en, r_mem_we, w_mem_we;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata;
  logic              r_busy, w_busy;
  logic              w_arb, w_pick_if;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_owner_if  <= 1'b0;
      r_we        <= 1'b0;
      r_lat       <= '0;
      r_starve    <= '0;
      r_if_gnt    <= 1'b0;
      r_dm_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_owner_if  <= w_owner_if;
      r_we        <= w_we;
      r_lat       <= w_lat;
      r_starve    <= w_starve;
      r_if_gnt    <= w_if_gnt;
      r_dm_gnt    <= w_dm_gnt;
      r_if_rvalid <= w_if_rvalid;
      r_dm_rvalid <= w_dm_rvalid;
      r_if_rdata  <= w_if_rdata;
      r_dm_rdata  <= w_dm_rdata;
      r_mem_en    <= w_mem_en;
      r_mem_we    <= w_mem_we;
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      r_busy      <= w_busy;
    end
  end

  // Outputs are computed for the next cycle, so the arbitration edge already
  // presents the grant and memory strobe during the ACCESS cycle.
  always_comb begin
    w_state     = r_state;
    w_owner_if  = r_owner_if;
    w_we        = r_we;
    w_lat       = r_lat;
    w_starve    = r_starve;
    w_if_gnt    = 1'b0;
    w_dm_gnt    = 1'b0;
    w_if_rvalid = 1'b0;
    w_dm_rvalid = 1'b0;
    w_if_rdata  = r_if_rdata;
    w_dm_rdata  = r_dm_rdata;
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    w_arb       = 1'b0;
    w_pick_if   = if_req && (!dm_req || (r_starve == c_STARVE_MAX));

    case (r_state)
      S_IDLE: w_arb = 1'b1;
      S_ACCESS: begin
        w_lat   = c_LAT;
        w_state = S_WAIT;
      end
      S_WAIT: begin
        if (r_lat == 3'd1) begin
          w_state = S_RESP;
          if (r_owner_if) begin
            w_if_rdata  = mem_rdata;
            w_if_rvalid = 1'b1;
          end else begin
            if (!r_we) w_dm_rdata = mem_rdata;
            w_dm_rvalid = 1'b1;
          end
        end else begin
          w_lat = r_lat - 3'd1;
        end
      end
      S_RESP: begin
        w_arb   = 1'b1;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase

    if (w_arb) begin
      if (!if_req) w_starve = '0;
      if (w_pick_if) begin
        w_state    = S_ACCESS;
        w_owner_if = 1'b1;
        w_we       = 1'b0;
        w_if_gnt   = 1'b1;
        w_mem_en   = 1'b1;
        w_mem_addr = if_addr;
        w_starve   = '0;
      end else if (dm_req) begin
        w_state     = S_ACCESS;
        w_owner_if  = 1'b0;
        w_we        = dm_we;
        w_dm_gnt    = 1'b1;
        w_mem_en    = 1'b1;
        w_mem_we    = dm_we;
        w_mem_addr  = dm_addr;
        w_mem_wdata = dm_wdata;
        // Count data wins that bypassed a waiting fetch; saturates at the limit.
        if (if_req && (r_starve != c_STARVE_MAX)) w_starve = r_starve + c_STARVE_W'(1);
      end
    end

    w_busy = (w_state != S_IDLE);
  end

  assign if_gnt    = r_if_gnt;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign dm_gnt    = r_dm_gnt;
  assign dm_rvalid = r_dm_rvalid;
  assign dm_rdata  = r_dm_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// Bench for mem_arbiter: directed scenarios plus random traffic against a
// transaction-timeline reference model and a behavioural latency memory.
module tb_mem_arbiter;
  localparam int LAT  = 1;
  localparam int LAT3 = 3;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        if_req, dm_req, dm_we;
  logic [11:0] if_addr, dm_addr;
  logic [31:0] dm_wdata;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, busy;
  logic [31:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic [11:0] mem_addr;

  logic        if_req3, zero1;
  logic [11:0] if_addr3, zero12;
  logic [31:0] zero32;
  logic        if_gnt3, if_rvalid3, dm_gnt3, dm_rvalid3, mem_en3, mem_we3, busy3;
  logic [31:0] if_rdata3, dm_rdata3, mem_wdata3, mem_rdata3;
  logic [11:0] mem_addr3;

  mem_arbiter #(.ADDR_W(12), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy));

  mem_arbiter #(.ADDR_W(12), .DATA_W(32), .MEM_LAT(LAT3), .STARVE_MAX(SMAX)) dut3 (
    .clk(clk), .reset(reset),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .dm_req(zero1), .dm_we(zero1), .dm_addr(zero12), .dm_wdata(zero32),
    .dm_gnt(dm_gnt3), .dm_rvalid(dm_rvalid3), .dm_rdata(dm_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3));

  // Behavioural memory: data is only valid in the cycle MEM_LAT after mem_en.
  logic [31:0] dev_mem [64];
  logic [5:0]  dev_addr, dev_addr3;
  int          dev_cnt = 0, dev_cnt3 = 0;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'h8C02_0000 : 32'h1000_0000 + 32'(i) * 32'h0101;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) dev_mem[i] = init_word(i);
      dev_cnt  <= 0;
      dev_cnt3 <= 0;
    end else begin
      if (mem_en) begin
        if (mem_we) dev_mem[mem_addr[5:0]] = mem_wdata;
        dev_addr <= mem_addr[5:0];
        dev_cnt  <= LAT;
      end else if (dev_cnt != 0) dev_cnt <= dev_cnt - 1;
      if (mem_en3) begin
        dev_addr3 <= mem_addr3[5:0];
        dev_cnt3  <= LAT3;
      end else if (dev_cnt3 != 0) dev_cnt3 <= dev_cnt3 - 1;
    end
  end
  assign mem_rdata  = (dev_cnt == 1)  ? dev_mem[dev_addr]  : 32'h5A5A_A5A5;
  assign mem_rdata3 = (dev_cnt3 == 1) ? dev_mem[dev_addr3] : 32'h5A5A_A5A5;

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Timeline reference model: one transaction in flight at a time.
  int          cyc, st, m_gnt_c, m_rv_c;
  bit          m_act, m_if, m_we, if_granted, dm_granted;
  logic [11:0] m_addr, e_mem_addr;
  logic [31:0] m_rdata_exp, e_if_rdata, e_dm_rdata, e_mem_wdata;
  logic [31:0] ref_mem [64];

  task automatic model_reset();
    m_act = 0; st = 0; e_if_rdata = 0; e_dm_rdata = 0; e_mem_addr = 0; e_mem_wdata = 0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
  endtask

  task automatic model_arb();
    if (m_act && cyc != m_rv_c) return;
    m_act = 0;
    if (!if_req) st = 0;
    if (if_req && (!dm_req || st == SMAX)) begin
      m_act = 1; m_if = 1; m_we = 0; m_addr = if_addr; st = 0;
    end else if (dm_req) begin
      m_act = 1; m_if = 0; m_we = dm_we; m_addr = dm_addr;
      if (if_req && st < SMAX) st++;
      if (dm_we) begin
        ref_mem[dm_addr[5:0]] = dm_wdata;
        e_mem_wdata = dm_wdata;
      end
    end
    if (m_act) begin
      m_gnt_c = cyc + 1;
      m_rv_c = cyc + 2 + LAT;
      e_mem_addr = m_addr;
      if (!m_we) m_rdata_exp = ref_mem[m_addr[5:0]];
    end
  endtask

  task automatic check_cycle();
    bit g, r;
    g = m_act && cyc == m_gnt_c;
    r = m_act && cyc == m_rv_c;
    if (r && m_if) e_if_rdata = m_rdata_exp;
    if (r && !m_if && !m_we) e_dm_rdata = m_rdata_exp;
    check("if_gnt", 32'(if_gnt), 32'(g && m_if));
    check("dm_gnt", 32'(dm_gnt), 32'(g && !m_if));
    check("mem_en", 32'(mem_en), 32'(g));
    check("mem_we", 32'(mem_we), 32'(g && m_we));
    check("mem_addr", 32'(mem_addr), 32'(e_mem_addr));
    if (g && m_we) check("mem_wdata", mem_wdata, e_mem_wdata);
    check("if_rvalid", 32'(if_rvalid), 32'(r && m_if));
    check("dm_rvalid", 32'(dm_rvalid), 32'(r && !m_if));
    check("if_rdata", if_rdata, e_if_rdata);
    check("dm_rdata", dm_rdata, e_dm_rdata);
    check("busy", 32'(busy), 32'(m_act && cyc >= m_gnt_c));
    if_granted = g && m_if;
    dm_granted = g && !m_if;
  endtask

  task automatic tick();
    model_arb();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_gnt"}, 32'({if_gnt, dm_gnt, if_gnt3, dm_gnt3}), 32'd0);
    check({pfx, "_rvalid"}, 32'({if_rvalid, dm_rvalid, if_rvalid3, dm_rvalid3}), 32'd0);
    check({pfx, "_mem_en_we"}, 32'({mem_en, mem_we, mem_en3, mem_we3}), 32'd0);
    check({pfx, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({pfx, "_mem_wdata"}, mem_wdata, 32'd0);
    check({pfx, "_if_rdata"}, if_rdata, 32'd0);
    check({pfx, "_dm_rdata"}, dm_rdata, 32'd0);
    check({pfx, "_busy"}, 32'({busy, busy3}), 32'd0);
  endtask

  int   n_gnt;
  int   order [8];
  logic [31:0] exp_order;

  initial begin
    reset = 1'b0; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    if_req3 = 0; if_addr3 = 0; zero1 = 0; zero12 = 0; zero32 = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    cyc = 0;
    model_reset();

    // Single fetch of address 0x004.
    if_req = 1; if_addr = 12'h004;
    tick();
    if_req = 0;
    tick(); tick();
    check("fetch_rdata", if_rdata, 32'h8C02_0000);
    tick(); tick();

    // Simultaneous requests: data wins, fetch follows from the RESP arbitration.
    dm_req = 1; dm_we = 0; dm_addr = 12'h010; if_req = 1; if_addr = 12'h008;
    tick();
    dm_req = 0;
    tick(); tick();
    check("simul_dm_rvalid", 32'(dm_rvalid), 32'd1);
    tick();
    check("simul_if_gnt", 32'(if_gnt), 32'd1);
    if_req = 0;
    tick(); tick(); tick();

    // Starvation: both held; the fifth grant must go to fetch.
    for (int i = 0; i < 8; i++) order[i] = 2;
    n_gnt = 0;
    dm_req = 1; dm_addr = 12'h010; if_req = 1; if_addr = 12'h00C;
    for (int i = 0; i < 18; i++) begin
      tick();
      if ((if_gnt || dm_gnt) && n_gnt < 8) begin
        order[n_gnt] = if_gnt ? 1 : 0;
        n_gnt++;
      end
    end
    dm_req = 0; if_req = 0;
    tick(); tick();
    check("starve_count", 32'(n_gnt), 32'd6);
    exp_order = 32'b010000;
    for (int i = 0; i < 6; i++) check("starve_order", 32'(order[i]), 32'(exp_order[i]));

    // Store then load the same address.
    dm_req = 1; dm_we = 1; dm_addr = 12'h020; dm_wdata = 32'hDEAD_BEEF;
    tick();
    dm_req = 0;
    tick(); tick();
    dm_req = 1; dm_we = 0;
    tick();
    dm_req = 0;
    tick(); tick();
    check("load_after_store", dm_rdata, 32'hDEAD_BEEF);
    tick();

    // Latency 3 instance: gnt in cycle 1, rvalid in cycle 5.
    if_req3 = 1; if_addr3 = 12'h008;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) if_req3 = 0;
      check("lat3_if_gnt", 32'(if_gnt3), 32'(k == 1));
      check("lat3_mem_en", 32'({mem_en3, mem_we3}), (k == 1) ? 32'd2 : 32'd0);
      check("lat3_if_rvalid", 32'(if_rvalid3), 32'(k == 5));
      check("lat3_busy", 32'(busy3), 32'(k >= 1 && k <= 5));
      check("lat3_dm_side", 32'({dm_gnt3, dm_rvalid3}), 32'd0);
      check("lat3_dm_rdata", dm_rdata3, 32'd0);
      check("lat3_mem_wdata", mem_wdata3, 32'd0);
      if (k >= 1) check("lat3_mem_addr", 32'(mem_addr3), 32'h8);
      if (k >= 5) check("lat3_if_rdata", if_rdata3, init_word(8));
    end

    // Asynchronous reset while waiting on memory.
    if_req = 1; if_addr = 12'h00C;
    tick();
    if_req = 0;
    tick();
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b1;
    model_reset();
    repeat (4) tick();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      if (if_granted || !if_req) begin
        if ($urandom_range(0, 2) == 0) begin
          if_req = 1; if_addr = 12'($urandom_range(0, 63));
        end else if_req = 0;
      end
      if (dm_granted || !dm_req) begin
        if ($urandom_range(0, 2) == 0) begin
          dm_req = 1; dm_we = 1'($urandom_range(0, 1));
          dm_addr = 12'($urandom_range(0, 63)); dm_wdata = $urandom;
        end else dm_req = 0;
      end
      tick();
    end
    if_req = 0; dm_req = 0;
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
